// File: rtl/mab_sequencer.sv
// Per-instruction MAB/strobe sequencer for the MSP430 datapath: fetch, source/destination
// extension and operand reads, execute, then writeback or push, with memory wait-state timeout.
module mab_sequencer #(
  parameter int SEL_W        = 3,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       FMT,
  input  logic [1:0]       AS,
  input  logic             AD,
  input  logic             SRC_IS_PC,
  input  logic             SRC_IS_CG,
  input  logic             OP_PUSH,
  input  logic             WB_EN,
  input  logic             MEM_RDY,
  input  logic             HALT,
  output logic [SEL_W-1:0] MAB_SEL,
  output logic             MEM_RD,
  output logic             MEM_WR,
  output logic             IR_LD,
  output logic             PC_INC,
  output logic             SRC_INC,
  output logic             SP_DEC,
  output logic             EXT_LD_SRC,
  output logic             EXT_LD_DST,
  output logic             OP_LD_SRC,
  output logic             OP_LD_DST,
  output logic             EXEC_EN,
  output logic             BUS_ERR,
  output logic [3:0]       STATE
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_SRC_EXT = 4'd2,
    S_SRC_RD  = 4'd3,
    S_DST_EXT = 4'd4,
    S_DST_RD  = 4'd5,
    S_EXEC    = 4'd6,
    S_DST_WR  = 4'd7,
    S_PUSH_WR = 4'd8
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_fmt, r_as;
  logic       r_ad, r_pc, r_cg, r_push, r_wb;
  logic [7:0] r_cnt, w_cnt_nxt;

  logic [SEL_W-1:0] w_sel;
  logic w_rd, w_wr, w_ir, w_pci, w_sinc, w_spd, w_exs, w_exd, w_ops, w_opd, w_ex;
  logic w_tmo;

  // Timeout fires on the MEM_RDY=0 cycle that would bring the counter to WAIT_TIMEOUT
  assign w_tmo = (w_rd | w_wr) & ~MEM_RDY & ((r_cnt + 8'd1) == 8'(WAIT_TIMEOUT));

  always_comb begin
    w_next = r_state;
    w_sel  = '0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_ir   = 1'b0;
    w_pci  = 1'b0;
    w_sinc = 1'b0;
    w_spd  = 1'b0;
    w_exs  = 1'b0;
    w_exd  = 1'b0;
    w_ops  = 1'b0;
    w_opd  = 1'b0;
    w_ex   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!HALT) begin
          w_rd = 1'b1;
          if (MEM_RDY) begin
            w_ir   = 1'b1;
            w_pci  = 1'b1;
            w_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        // Decode steers on live inputs; the same edge latches them for later states
        case (FMT)
          2'd0, 2'd1: begin
            if (AS == 2'd0 || SRC_IS_CG)
              w_next = (FMT == 2'd0 && AD) ? S_DST_EXT : S_EXEC;
            else if (AS == 2'd1)
              w_next = S_SRC_EXT;
            else
              w_next = S_SRC_RD;
          end
          2'd2:    w_next = S_EXEC;
          default: w_next = S_FETCH;
        endcase
      end
      S_SRC_EXT: begin
        w_rd = 1'b1;
        if (MEM_RDY) begin
          w_pci  = 1'b1;
          w_exs  = 1'b1;
          w_next = S_SRC_RD;
        end
      end
      S_SRC_RD: begin
        w_rd = 1'b1;
        case (r_as)
          2'd1:    w_sel = SEL_W'(2);
          2'd3:    w_sel = r_pc ? SEL_W'(0) : SEL_W'(3);
          default: w_sel = SEL_W'(3);
        endcase
        if (MEM_RDY) begin
          w_ops  = 1'b1;
          w_pci  = (r_as == 2'd3) & r_pc;
          w_sinc = (r_as == 2'd3) & ~r_pc;
          w_next = (r_fmt == 2'd0 && r_ad) ? S_DST_EXT : S_EXEC;
        end
      end
      S_DST_EXT: begin
        w_rd = 1'b1;
        if (MEM_RDY) begin
          w_pci  = 1'b1;
          w_exd  = 1'b1;
          w_next = S_DST_RD;
        end
      end
      S_DST_RD: begin
        w_rd  = 1'b1;
        w_sel = SEL_W'(2);
        if (MEM_RDY) begin
          w_opd  = 1'b1;
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_ex  = 1'b1;
        w_spd = (r_fmt == 2'd1) & r_push;
        if (r_fmt == 2'd0 && r_ad && r_wb)
          w_next = S_DST_WR;
        else if (r_fmt == 2'd1 && r_push)
          w_next = S_PUSH_WR;
        else if (r_fmt == 2'd1 && r_wb && (r_as == 2'd1 || r_as == 2'd2))
          w_next = S_DST_WR;
        else
          w_next = S_FETCH;
      end
      S_DST_WR: begin
        w_wr  = 1'b1;
        w_sel = (r_fmt == 2'd1 && r_as == 2'd2) ? SEL_W'(3) : SEL_W'(2);
        if (MEM_RDY) w_next = S_FETCH;
      end
      S_PUSH_WR: begin
        w_wr  = 1'b1;
        w_sel = SEL_W'(5);
        if (MEM_RDY) w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (w_tmo) w_next = S_FETCH;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_next != r_state || w_tmo)
      w_cnt_nxt = '0;
    else if ((w_rd | w_wr) && !MEM_RDY)
      w_cnt_nxt = r_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_fmt   <= '0;
      r_as    <= '0;
      r_ad    <= 1'b0;
      r_pc    <= 1'b0;
      r_cg    <= 1'b0;
      r_push  <= 1'b0;
      r_wb    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_DECODE) begin
        r_fmt  <= FMT;
        r_as   <= AS;
        r_ad   <= AD;
        r_pc   <= SRC_IS_PC;
        r_cg   <= SRC_IS_CG;
        r_push <= OP_PUSH;
        r_wb   <= WB_EN;
      end
    end
  end

  // Reset masks every output in the reset cycle itself, not just from the next one
  always_comb begin
    MAB_SEL    = rst ? '0 : w_sel;
    MEM_RD     = ~rst & w_rd;
    MEM_WR     = ~rst & w_wr;
    IR_LD      = ~rst & w_ir;
    PC_INC     = ~rst & w_pci;
    SRC_INC    = ~rst & w_sinc;
    SP_DEC     = ~rst & w_spd;
    EXT_LD_SRC = ~rst & w_exs;
    EXT_LD_DST = ~rst & w_exd;
    OP_LD_SRC  = ~rst & w_ops;
    OP_LD_DST  = ~rst & w_opd;
    EXEC_EN    = ~rst & w_ex;
    BUS_ERR    = ~rst & w_tmo;
    STATE      = rst ? 4'd0 : r_state;
  end

endmodule
